theremin_synth: RTL and testbench
=================================

Name: theremin_synth

Overview:
Downstream audio stage for the ultrasonic theremin. It consumes the pitch_mod/volume_mod words and their data_ready strobe from the sensor block. It applies a per-sample glide (slew) to both controls, drives a phase-accumulator oscillator with selectable waveform, and scales the waveform by volume. The result is an 8-bit sample and a glitch-free PWM audio pin for the pad ring.

Parameters:
SAMPLE_DIV, 256, clocks per audio sample tick (>=2)
PHASE_BITS, 24, phase accumulator width (>=17)
FREQ_BASE, 64, constant added to pitch to form the phase increment (minimum tone)

Ports:
clk  in  1  system clock
rst_n  in  1  reset, synchronous, active-low
enable  in  1  synth run enable
wave_sel  in  2  0 saw, 1 square, 2 triangle, 3 mute
glide_shift  in  4  glide coefficient; 0 = no glide
mod_valid  in  1  one-cycle strobe; capture pitch_mod/volume_mod
pitch_mod  in  16  pitch control word (unsigned)
volume_mod  in  16  volume control word (unsigned)
sample  out  8  current scaled audio sample
sample_stb  out  1  one-cycle pulse when sample updates
pwm_out  out  1  PWM audio output

Behaviour:
- Reset: one clock and one reset (clk, rst_n); reset is synchronous and active-low. All of the following clear to 0: pitch_tgt, vol_tgt, pitch_cur, vol_cur, phase, prescaler, pwm_cnt, duty, sample, sample_stb, pwm_out. Reset asserted mid-operation takes effect at the next edge; no partial state survives.
- Capture:
  - mod_valid=1 latches pitch_mod->pitch_tgt and volume_mod->vol_tgt on that edge.
  - Capture is independent of enable.
- Prescaler:
  - Counts 0..SAMPLE_DIV-1, then wraps.
  - tick=1 in the cycle the count equals SAMPLE_DIV-1.
  - enable=0 holds the prescaler at 0.
- On tick (cycle T), with enable=1:
  - Glide, applied independently to pitch and volume:
    - d = tgt - cur, computed as a 17-bit signed value.
    - s = d >>> glide_shift (arithmetic shift).
    - If glide_shift=0, cur <= tgt.
    - Else if s==0 and d!=0, cur <= cur ± 1 (sign of d), which guarantees convergence.
    - Otherwise cur <= cur + s.
  - Phase: phase <= phase + ({1'b0,pitch_cur} + FREQ_BASE), using pitch_cur before its update in the same cycle.
    - The increment is zero-extended to PHASE_BITS.
    - The phase wraps modulo 2^PHASE_BITS.
- Sample stage (cycle T+1, registered):
  - p = phase[PHASE_BITS-1 -: 8], taken after the T update.
  - w = saw: p | square: p[7]?255:0 | triangle: p[7] ? ~{p[6:0],0} : {p[6:0],0} | mute: 0.
  - sample <= (w * vol_cur[15:8]) >> 8, an 8-bit result.
  - sample_stb=1 for exactly this cycle. Tick-to-sample_stb latency is exactly 1 clock.
- PWM:
  - pwm_cnt is a free-running 8-bit counter.
  - When pwm_cnt==255, duty <= sample on that edge. Duty therefore updates only at the period boundary, with no mid-period glitch.
  - pwm_out is registered: pwm_out <= (pwm_cnt_next < duty).
  - Duty 0 gives a constant low; duty 255 gives 255 high clocks out of every 256.
- enable=0:
  - phase, prescaler and sample are forced to 0; sample_stb=0.
  - pitch_cur and vol_cur hold their values.
  - PWM keeps running and drains to 0 at the next period boundary.
- mod_valid coincident with tick: glide uses the old tgt; the new tgt is visible from the next tick.
- Width rules:
  - All arithmetic is unsigned except the glide difference.
  - The phase sum truncates; there is no saturation anywhere.
  - The glide result lies between cur and tgt, so no overflow is possible.

Decomposition:
- Shared package theremin_pkg: wave_sel encodings (WAVE_SAW=0, WAVE_SQUARE=1, WAVE_TRI=2, WAVE_MUTE=3) and the PWM resolution constant (8).
- Natural sub-module: theremin_pwm, covering the 8-bit counter, duty shadow register and comparator.
- Glide logic is instantiated twice as a function or generate; it is not a separate module.

Test Plan:
1. Reset and enable (SAMPLE_DIV=4):
   - Assert rst_n=0 mid-run for 1 cycle -> sample=0, pwm_out=0, phase=0 next cycle.
   - Enable=1 -> first sample_stb 4 cycles later, then every 4.
2. Sawtooth step:
   - Stimulus: glide_shift=0, wave_sel=0, mod_valid with pitch_mod=0xFFC0, volume_mod=0xFF00 (increment 0x10000).
   - Response: p = 1,2,3,... on successive ticks; sample = 0,1,2,... (k*255>>8).
3. Glide:
   - Stimulus: glide_shift=2, pitch_cur=0, pitch_tgt=0x0100.
   - Response: pitch_cur = 0x40, 0x70, 0x94 on successive ticks; converges exactly to 0x0100 via ±1 steps.
   - Repeat downward from 0x0100 to 0 to check the sign path.
4. Waveforms at volume 0xFF00, with p forced to 0x40 and then 0xC0:
   - square -> 0 then 254.
   - triangle -> 127 then 126.
   - mute -> 0.
5. PWM:
   - sample=128 -> after the next pwm_cnt wrap, exactly 128 high clocks per 256.
   - sample changed mid-period -> no duty change until pwm_cnt==255.
6. Coincident events:
   - mod_valid on the tick cycle -> that tick uses the old target; the next tick uses the new one.
   - enable dropped mid-period -> sample_stb stops; pwm_out reaches 0 after at most 512 clocks.

Source files
------------

// File: rtl/theremin_pkg.sv
// Shared definitions for the theremin audio stage: waveform encodings,
// PWM resolution and the per-sample glide step used for pitch and volume.
package theremin_pkg;

    typedef enum logic [1:0] {
        WAVE_SAW    = 2'd0,
        WAVE_SQUARE = 2'd1,
        WAVE_TRI    = 2'd2,
        WAVE_MUTE   = 2'd3
    } wave_e;

    localparam int unsigned PWM_BITS = 8;

    // One glide step from cur toward tgt; +/-1 fallback guarantees convergence.
    function automatic logic [15:0] glide_step(input logic [15:0] cur,
                                               input logic [15:0] tgt,
                                               input logic [3:0]  shift);
        logic signed [16:0] d;
        logic signed [16:0] s;
        d = $signed({1'b0, tgt}) - $signed({1'b0, cur});
        s = d >>> shift;
        if (shift == 4'd0) begin
            return tgt;
        end else if (s == 17'sd0 && d != 17'sd0) begin
            return d[16] ? cur - 16'd1 : cur + 16'd1;
        end else begin
            return cur + s[15:0];
        end
    endfunction

endpackage

// File: rtl/theremin_synth_pwm.sv
// PWM audio output: free-running counter, duty shadow loaded only at the
// period boundary, registered comparator.
module theremin_pwm
    import theremin_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [PWM_BITS-1:0] level,
    output logic                pwm_out
);

    logic [PWM_BITS-1:0] cnt;
    logic [PWM_BITS-1:0] duty;
    logic [PWM_BITS-1:0] cnt_nxt_c;
    logic [PWM_BITS-1:0] duty_nxt_c;

    // Compare against the duty in force for the next count so a new level
    // takes effect cleanly from count 0.
    always_comb begin
        cnt_nxt_c  = cnt + PWM_BITS'(1);
        duty_nxt_c = duty;
        if (cnt == '1) begin
            duty_nxt_c = level;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt     <= '0;
            duty    <= '0;
            pwm_out <= 1'b0;
        end else begin
            cnt     <= cnt_nxt_c;
            duty    <= duty_nxt_c;
            pwm_out <= (cnt_nxt_c < duty_nxt_c);
        end
    end

endmodule

// File: rtl/theremin_synth.sv
// Theremin audio stage: glides pitch/volume controls, runs a phase-accumulator
// oscillator, scales the selected waveform by volume and drives a PWM pin.
module theremin_synth
    import theremin_pkg::*;
#(
    parameter int unsigned SAMPLE_DIV = 256,
    parameter int unsigned PHASE_BITS = 24,
    parameter int unsigned FREQ_BASE  = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic [1:0]  wave_sel,
    input  logic [3:0]  glide_shift,
    input  logic        mod_valid,
    input  logic [15:0] pitch_mod,
    input  logic [15:0] volume_mod,
    output logic [7:0]  sample,
    output logic        sample_stb,
    output logic        pwm_out
);

    localparam int unsigned PRE_W = $clog2(SAMPLE_DIV);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SAMPLE_DIV - 1);

    logic [PRE_W-1:0]      prescaler;
    logic [15:0]           pitch_tgt;
    logic [15:0]           vol_tgt;
    logic [15:0]           pitch_cur;
    logic [15:0]           vol_cur;
    logic [PHASE_BITS-1:0] phase;

    logic                  tick_c;
    logic [15:0]           pitch_nxt_c;
    logic [15:0]           vol_nxt_c;
    logic [PHASE_BITS-1:0] incr_c;
    logic [PHASE_BITS-1:0] phase_nxt_c;
    logic [7:0]            p_c;
    logic [7:0]            wave_c;
    logic [15:0]           prod_c;

    // Sample-rate datapath; the sample is formed from the post-tick phase/volume.
    always_comb begin
        tick_c      = enable && (prescaler == PRE_LAST);
        pitch_nxt_c = glide_step(pitch_cur, pitch_tgt, glide_shift);
        vol_nxt_c   = glide_step(vol_cur, vol_tgt, glide_shift);
        incr_c      = PHASE_BITS'({1'b0, pitch_cur}) + PHASE_BITS'(FREQ_BASE);
        phase_nxt_c = phase + incr_c;
        p_c         = phase_nxt_c[PHASE_BITS-1 -: 8];
        wave_c      = '0;
        case (wave_e'(wave_sel))
            WAVE_SAW:    wave_c = p_c;
            WAVE_SQUARE: wave_c = p_c[7] ? 8'hFF : 8'h00;
            WAVE_TRI:    wave_c = p_c[7] ? ~{p_c[6:0], 1'b0} : {p_c[6:0], 1'b0};
            WAVE_MUTE:   wave_c = '0;
        endcase
        prod_c = 16'(wave_c) * 16'(vol_nxt_c[15:8]);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prescaler  <= '0;
            pitch_tgt  <= '0;
            vol_tgt    <= '0;
            pitch_cur  <= '0;
            vol_cur    <= '0;
            phase      <= '0;
            sample     <= '0;
            sample_stb <= 1'b0;
        end else begin
            if (mod_valid) begin
                pitch_tgt <= pitch_mod;
                vol_tgt   <= volume_mod;
            end
            // Disabled: oscillator parked at zero, glide state frozen.
            if (!enable) begin
                prescaler  <= '0;
                phase      <= '0;
                sample     <= '0;
                sample_stb <= 1'b0;
            end else begin
                prescaler  <= tick_c ? '0 : prescaler + PRE_W'(1);
                sample_stb <= tick_c;
                if (tick_c) begin
                    pitch_cur <= pitch_nxt_c;
                    vol_cur   <= vol_nxt_c;
                    phase     <= phase_nxt_c;
                    sample    <= prod_c[15:8];
                end
            end
        end
    end

    theremin_pwm u_pwm (
        .clk     (clk),
        .rst_n   (rst_n),
        .level   (sample),
        .pwm_out (pwm_out)
    );

endmodule

// File: tb/tb_theremin_synth.sv
// Directed bench for theremin_synth at SAMPLE_DIV=4; expected values are
// hand-derived from the oscillator, glide and PWM rules.
module tb_theremin_synth;
    import theremin_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable;
    logic [1:0]  wave_sel;
    logic [3:0]  glide_shift;
    logic        mod_valid;
    logic [15:0] pitch_mod;
    logic [15:0] volume_mod;
    logic [7:0]  sample;
    logic        sample_stb;
    logic        pwm_out;

    int vectors = 0;
    int errors  = 0;

    // Reference PWM period position, cleared by reset like the design counter.
    logic [7:0] mcnt;

    theremin_synth #(
        .SAMPLE_DIV (4),
        .PHASE_BITS (24),
        .FREQ_BASE  (64)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .enable      (enable),
        .wave_sel    (wave_sel),
        .glide_shift (glide_shift),
        .mod_valid   (mod_valid),
        .pitch_mod   (pitch_mod),
        .volume_mod  (volume_mod),
        .sample      (sample),
        .sample_stb  (sample_stb),
        .pwm_out     (pwm_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst_n) mcnt <= 8'd0;
        else        mcnt <= mcnt + 8'd1;
    end

    task automatic wait_stb(input int limit, output int n);
        bit done;
        n = 0;
        done = 1'b0;
        while (!done) begin
            @(negedge clk);
            n++;
            if (sample_stb === 1'b1) done = 1'b1;
            else if (n >= limit) begin
                n = -1;
                done = 1'b1;
            end
        end
    endtask

    task automatic wait_mcnt(input logic [7:0] target, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (mcnt === target) ok = 1'b1;
        end
    endtask

    task automatic capture(input logic [15:0] p, input logic [15:0] v);
        mod_valid  = 1'b1;
        pitch_mod  = p;
        volume_mod = v;
        @(negedge clk);
        mod_valid  = 1'b0;
    endtask

    // Counts high clocks over one period; call at a negedge where mcnt==0.
    task automatic count_period(input int inject_at, output int highs);
        highs = 0;
        for (int i = 0; i < 256; i++) begin
            if (pwm_out === 1'b1) highs++;
            if (i == inject_at) begin
                mod_valid  = 1'b1;
                pitch_mod  = 16'h0000;
                volume_mod = 16'hFF00;
            end else begin
                mod_valid = 1'b0;
            end
            @(negedge clk);
        end
        mod_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; enable = 1'b0; wave_sel = 2'd0; glide_shift = 4'd0;
        mod_valid = 1'b0; pitch_mod = '0; volume_mod = '0;
        repeat (3) @(negedge clk);
        vectors++;
        if (sample !== 8'd0 || sample_stb !== 1'b0 || pwm_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: sample=%0d stb=%b pwm=%b, want 0/0/0", sample, sample_stb, pwm_out);
        end
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        vectors++;
        if (sample_stb !== 1'b0 || pwm_out !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: stb=%b pwm=%b, want 0/0", sample_stb, pwm_out);
        end
    endtask

    // First tick still adds the pre-capture pitch (0+64), so p runs 0,1,2,...
    task automatic test_saw_cadence(input string tag);
        int n;
        logic [7:0] exp;
        enable = 1'b0; wave_sel = WAVE_SAW; glide_shift = 4'd0;
        @(negedge clk);
        capture(16'hFFC0, 16'hFF00);
        enable = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            wait_stb(8, n);
            exp = (k <= 2) ? 8'd0 : 8'(k - 2);
            vectors++;
            if (n != 4) begin
                errors++;
                $display("FAIL %s_cadence k=%0d: gap=%0d, want 4", tag, k, n);
            end
            vectors++;
            if (sample !== exp) begin
                errors++;
                $display("FAIL %s_saw k=%0d: sample=%0d, want %0d", tag, k, sample, exp);
            end
        end
    endtask

    task automatic test_waveforms();
        int n;
        logic [1:0] wv [3];
        logic [7:0] lo [3];
        logic [7:0] hi [3];
        wv[0] = WAVE_SQUARE; lo[0] = 8'd0;   hi[0] = 8'd254;
        wv[1] = WAVE_TRI;    lo[1] = 8'd127; hi[1] = 8'd126;
        wv[2] = WAVE_MUTE;   lo[2] = 8'd0;   hi[2] = 8'd0;
        for (int w = 0; w < 3; w++) begin
            enable = 1'b0;
            wave_sel = wv[w];
            @(negedge clk);
            enable = 1'b1;
            for (int k = 1; k <= 192; k++) begin
                wait_stb(8, n);
                if (n < 0) begin
                    vectors++; errors++;
                    $display("FAIL wave%0d_timeout k=%0d: no sample_stb within 8 clocks", w, k);
                end
                if (k == 64) begin
                    vectors++;
                    if (sample !== lo[w]) begin
                        errors++;
                        $display("FAIL wave%0d_p40: sample=%0d, want %0d", w, sample, lo[w]);
                    end
                end
                if (k == 192) begin
                    vectors++;
                    if (sample !== hi[w]) begin
                        errors++;
                        $display("FAIL wave%0d_pC0: sample=%0d, want %0d", w, sample, hi[w]);
                    end
                end
            end
        end
    endtask

    // Volume glide observed through a square wave parked at p=0x81.
    task automatic test_glide();
        int n;
        bit reached;
        logic [7:0] up [3];
        logic [7:0] dn [2];
        up[0] = 8'd62; up[1] = 8'd110; up[2] = 8'd146;
        dn[0] = 8'd190; dn[1] = 8'd142;
        enable = 1'b0; wave_sel = WAVE_SQUARE; glide_shift = 4'd0;
        @(negedge clk);
        enable = 1'b1;
        for (int k = 1; k <= 128; k++) wait_stb(8, n);
        vectors++;
        if (sample !== 8'd254) begin
            errors++;
            $display("FAIL glide_setup_p80: sample=%0d, want 254", sample);
        end
        capture(16'h0000, 16'h0000);
        wait_stb(8, n);
        vectors++;
        if (sample !== 8'd0) begin
            errors++;
            $display("FAIL glide_setup_vol0: sample=%0d, want 0", sample);
        end
        glide_shift = 4'd2;
        capture(16'h0000, 16'hFF00);
        for (int i = 0; i < 3; i++) begin
            wait_stb(8, n);
            vectors++;
            if (sample !== up[i]) begin
                errors++;
                $display("FAIL glide_up step%0d: sample=%0d, want %0d", i, sample, up[i]);
            end
        end
        reached = 1'b0;
        for (int i = 0; i < 60 && !reached; i++) begin
            wait_stb(8, n);
            if (sample === 8'd254) reached = 1'b1;
        end
        vectors++;
        if (!reached) begin
            errors++;
            $display("FAIL glide_up_converge: sample=%0d, want 254 within 60 ticks", sample);
        end
        capture(16'h0000, 16'h0000);
        for (int i = 0; i < 2; i++) begin
            wait_stb(8, n);
            vectors++;
            if (sample !== dn[i]) begin
                errors++;
                $display("FAIL glide_down step%0d: sample=%0d, want %0d", i, sample, dn[i]);
            end
        end
        reached = 1'b0;
        for (int i = 0; i < 60 && !reached; i++) begin
            wait_stb(8, n);
            if (sample === 8'd0) reached = 1'b1;
        end
        vectors++;
        if (!reached) begin
            errors++;
            $display("FAIL glide_down_converge: sample=%0d, want 0 within 60 ticks", sample);
        end
    endtask

    task automatic test_coincident_capture();
        int n;
        glide_shift = 4'd0;
        wait_stb(8, n);
        wait_stb(8, n);
        repeat (3) @(negedge clk);
        mod_valid = 1'b1; pitch_mod = 16'h0000; volume_mod = 16'hFF00;
        @(negedge clk);
        mod_valid = 1'b0;
        vectors++;
        if (sample_stb !== 1'b1 || sample !== 8'd0) begin
            errors++;
            $display("FAIL coincident_old_tgt: stb=%b sample=%0d, want 1/0", sample_stb, sample);
        end
        wait_stb(8, n);
        vectors++;
        if (n != 4 || sample !== 8'd254) begin
            errors++;
            $display("FAIL coincident_new_tgt: gap=%0d sample=%0d, want 4/254", n, sample);
        end
    endtask

    task automatic test_pwm();
        int n;
        int h;
        bit ok;
        capture(16'h0000, 16'h8100);
        wait_stb(8, n);
        vectors++;
        if (sample !== 8'd128) begin
            errors++;
            $display("FAIL pwm_level: sample=%0d, want 128", sample);
        end
        wait_mcnt(8'd0, ok);
        vectors++;
        if (!ok) begin
            errors++;
            $display("FAIL pwm_boundary: period start not found within 300 clocks");
        end
        count_period(-1, h);
        vectors++;
        if (h != 128) begin
            errors++;
            $display("FAIL pwm_duty128: highs=%0d, want 128", h);
        end
        count_period(40, h);
        vectors++;
        if (h != 128) begin
            errors++;
            $display("FAIL pwm_midperiod_hold: highs=%0d, want 128", h);
        end
        count_period(-1, h);
        vectors++;
        if (h != 254) begin
            errors++;
            $display("FAIL pwm_duty254: highs=%0d, want 254", h);
        end
    endtask

    task automatic test_enable_drop();
        int h;
        int stbs;
        bit ok;
        repeat (100) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        vectors++;
        if (sample !== 8'd0 || sample_stb !== 1'b0) begin
            errors++;
            $display("FAIL disable_forces_zero: sample=%0d stb=%b, want 0/0", sample, sample_stb);
        end
        stbs = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (sample_stb === 1'b1) stbs++;
        end
        vectors++;
        if (stbs != 0) begin
            errors++;
            $display("FAIL disable_no_stb: strobes=%0d, want 0", stbs);
        end
        wait_mcnt(8'd0, ok);
        count_period(-1, h);
        vectors++;
        if (!ok || h != 0) begin
            errors++;
            $display("FAIL disable_pwm_drain: found=%0d highs=%0d, want 1/0", ok, h);
        end
    endtask

    task automatic test_reset_midrun();
        int n;
        wave_sel = WAVE_SAW;
        capture(16'hFFC0, 16'hFF00);
        enable = 1'b1;
        for (int k = 0; k < 4; k++) wait_stb(8, n);
        vectors++;
        if (sample !== 8'd2) begin
            errors++;
            $display("FAIL prereset_run: sample=%0d, want 2", sample);
        end
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        vectors++;
        if (sample !== 8'd0 || sample_stb !== 1'b0 || pwm_out !== 1'b0) begin
            errors++;
            $display("FAIL midrun_reset: sample=%0d stb=%b pwm=%b, want 0/0/0", sample, sample_stb, pwm_out);
        end
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_saw_cadence("first");
        test_waveforms();
        test_glide();
        test_coincident_capture();
        test_pwm();
        test_enable_drop();
        test_reset_midrun();
        test_saw_cadence("after_reset");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
